piso_shift_tx: RTL
==================

# piso_shift_tx

- Parallel-in, serial-out shift transmitter for the bidirectional shift-register path.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on `dout`.
- Shift direction is selected per word: right shift sends LSB first, left shift sends MSB first.
- Serves as the sending end feeding the serial inputs (`dr`/`dl`) of the team's shift-register receivers.

## Interface
- `WIDTH`, default 4: word width in bits, ≥2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  word offered on `load_data`.
- `load_data`  in  WIDTH  parallel word to transmit.
- `mode`  in  1  direction for the offered word: 1 = right (LSB first), 0 = left (MSB first); sampled only on acceptance.
- `load_ready`  out  1  block can accept a word this cycle.
- `dout`  out  1  serial data bit.
- `dout_valid`  out  1  `dout` carries a valid bit.
- `dout_last`  out  1  current bit is the final bit of its word.
- `busy`  out  1  a word is shifting or held.

## Operation
- FSM in `piso_pkg`, two states:
  - IDLE → SHIFT on handshake (`load_valid && load_ready`).
  - SHIFT → IDLE after the last bit when no next word is queued.
- On acceptance:
  - Shift register ← `load_data`.
  - Direction register ← `mode`.
  - Bit counter ← WIDTH-1.
- In SHIFT, each edge shifts one position toward the output end and fills the vacated bit with 0.
  - Right: `dout` = bit 0, the register shifts toward bit 0.
  - Left: `dout` = bit WIDTH-1, the register shifts toward bit WIDTH-1.
- Counter decrements once per bit. `dout_last` = SHIFT && counter == 0.
- `mode` and `load_data` changes mid-word are ignored.
- `dout` is forced 0 whenever `dout_valid` = 0.
- Without the preload feature:
  - `load_ready` = (state == IDLE) && !rst.
  - Consecutive words are separated by exactly one idle cycle.
- Reset (async, any time, including mid-word):
  - State IDLE, shift register 0, counter 0, hold buffer empty.
  - `dout`, `dout_valid`, `dout_last`, `busy` = 0. `load_ready` = 0 while `rst` is high, 1 in the first cycle after release.
  - A partially sent word is discarded. There is no resume.

## Timing
- Word accepted at edge k → its bits are valid in cycles k+1 … k+WIDTH; `dout_last` is high in cycle k+WIDTH.
- Latency from handshake to first bit: 1 cycle. All outputs are registered except `load_ready`.
- Without preload:
  - Edge k+WIDTH returns the FSM to IDLE, so `load_ready` = 1 in cycle k+WIDTH+1.
  - The earliest next first bit is cycle k+WIDTH+2.
- `busy` = 1 from cycle k+1 through the last bit (and while the hold buffer is occupied).

## Configuration
- Macro `PISO_SHIFT_TX_PRELOAD_EN`.
- Defined:
  - Adds a one-word hold buffer; `load_ready` = !hold_full && !rst.
  - A word accepted during SHIFT goes to the hold buffer together with its `mode`.
  - On the last-bit edge with the hold buffer full, the shift register, direction and counter reload directly from the hold buffer. Result: zero gap between words.
  - Handshake and last-bit drain on the same edge: the incoming word lands in the now-free buffer.
  - In IDLE, a loaded word goes straight into the shift register.
- Undefined: no hold buffer; behaviour exactly as in Operation.

## Structure
- `piso_pkg` contains:
  - State enum (`ST_IDLE`, `ST_SHIFT`).
  - Direction constants `DIR_LEFT` = 0, `DIR_RIGHT` = 1.
- Sub-module `piso_hold_buf`, instantiated only under `PISO_SHIFT_TX_PRELOAD_EN`:
  - One-entry register storing data + mode, with a full flag.
  - Push/pop interface, async reset to empty.

## Test plan
- Reset:
  - Assert `rst` for 3 cycles → `dout`, `dout_valid`, `dout_last`, `busy`, `load_ready` all 0.
  - Release → `load_ready` = 1 in the next cycle.
- Right shift: load 4'b1011 with `mode` = 1 → `dout` = 1,1,0,1 in cycles 1–4, `dout_valid` high for exactly 4 cycles, `dout_last` only in cycle 4.
- Left shift: load 4'b1011 with `mode` = 0 → `dout` = 1,0,1,1. Toggling `mode` during the word leaves the sequence unchanged.
- Back-to-back: hold `load_valid` high with 4'hA then 4'h5, `mode` = 1.
  - Without the macro: bits 0,1,0,1, one idle cycle, then 1,0,1,0.
  - With the macro: 8 contiguous valid bits 0,1,0,1,1,0,1,0, and `dout_last` in cycles 4 and 8.
- Mid-word reset: assert `rst` asynchronously during bit 2 of 4'hF → `dout_valid` and `dout` drop to 0 immediately. After release, the FSM is idle, the hold buffer is empty, and no remaining bits appear.
- Preload full: with the macro, shifting and holding one word → `load_ready` = 0. It returns to 1 the cycle after the held word moves into the shift register.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_shift_tx serial transmitter.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/piso_hold_buf.sv
// One-word hold buffer (data + direction) with full flag for piso_shift_tx.
// Compiled only when PISO_SHIFT_TX_PRELOAD_EN is defined.
`ifdef PISO_SHIFT_TX_PRELOAD_EN
module piso_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_mode,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             mode
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
      mode <= 1'b0;
    end else begin
      full <= push | (full & ~pop);
      if (push) begin
        data <= push_data;
        mode <= push_mode;
      end
    end
  end

endmodule
`endif

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter; LSB-first (right) or MSB-first (left) per word.
// Define PISO_SHIFT_TX_PRELOAD_EN to add a one-word hold buffer for gapless streaming.
module piso_shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             mode,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);
  import piso_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic             dir;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             load_sh;
  logic [WIDTH-1:0] ld_data;
  logic             ld_mode;

  assign accept = load_valid && load_ready;
  assign last   = (state == ST_SHIFT) && (cnt == '0);

`ifdef PISO_SHIFT_TX_PRELOAD_EN
  logic             hold_full;
  logic             hold_mode;
  logic [WIDTH-1:0] hold_data;
  logic             push;
  logic             pop;

  assign load_ready = !hold_full && !rst;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (load_data),
    .push_mode (mode),
    .full      (hold_full),
    .data      (hold_data),
    .mode      (hold_mode)
  );
`else
  assign load_ready = (state == ST_IDLE) && !rst;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_sh  = 1'b0;
    ld_data  = load_data;
    ld_mode  = mode;
`ifdef PISO_SHIFT_TX_PRELOAD_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SHIFT;
          load_sh  = 1'b1;
        end
      end
      ST_SHIFT: begin
`ifdef PISO_SHIFT_TX_PRELOAD_EN
        if (last) begin
          // Reload on the last-bit edge keeps the serial stream gapless.
          if (hold_full) begin
            pop     = 1'b1;
            push    = accept;
            load_sh = 1'b1;
            ld_data = hold_data;
            ld_mode = hold_mode;
          end else if (accept) begin
            load_sh = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          push = accept;
        end
`else
        if (last) state_nx = ST_IDLE;
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      dir   <= DIR_LEFT;
      cnt   <= '0;
    end else if (load_sh) begin
      shreg <= ld_data;
      dir   <= ld_mode;
      cnt   <= CW'(WIDTH - 1);
    end else if (state == ST_SHIFT) begin
      if (dir == DIR_RIGHT) shreg <= {1'b0, shreg[WIDTH-1:1]};
      else                  shreg <= {shreg[WIDTH-2:0], 1'b0};
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign dout_valid = (state == ST_SHIFT);
  assign dout       = dout_valid && ((dir == DIR_RIGHT) ? shreg[0] : shreg[WIDTH-1]);
  assign dout_last  = last;

`ifdef PISO_SHIFT_TX_PRELOAD_EN
  assign busy = dout_valid || hold_full;
`else
  assign busy = dout_valid;
`endif

endmodule
